fifo_burst_arbiter: RTL and testbench

- Round-robin, burst-granular arbiter that drains N_CH synchronous channel FIFOs into one shared output stream.
- Typical use: merging per-slot DAC/ADC sample FIFOs onto a single host-bound link.
- A channel is granted only when it holds a full burst, or any data while flush is asserted.
- Each output beat carries its channel index and an end-of-burst marker.

---
 rtl/fifo_burst_arbiter.sv | 135 +++++++++++++
 tb/tb_fifo_burst_arbiter.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_burst_arbiter.sv
// Round-robin arbiter that drains N_CH channel FIFOs into one output stream, one burst per grant.
// A channel qualifies with a full burst buffered, or with any data while flush is high.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | search for the next eligible channel starting at rr_ptr
// ST_XFER | stream the granted channel until remain words have moved
module fifo_burst_arbiter #(
    parameter int N_CH  = 4,
    parameter int Nb    = 8,
    parameter int M     = 2,
    parameter int BURST = 4,
    parameter int CW    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [N_CH*(M+1)-1:0] ch_count,
    input  logic [N_CH-1:0]       ch_valid,
    input  logic [N_CH*Nb-1:0]    ch_data,
    output logic [N_CH-1:0]       ch_ready,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [Nb-1:0]         out_data,
    output logic [CW-1:0]         out_chan,
    output logic                  out_last,
    output logic                  busy
);

    localparam logic [0:0]    ST_IDLE = 1'b0;
    localparam logic [0:0]    ST_XFER = 1'b1;
    localparam logic [M:0]    BURST_W = (M+1)'(BURST);
    localparam logic [M:0]    ONE_W   = (M+1)'(1);
    localparam logic [CW-1:0] LAST_CH = CW'(N_CH - 1);
    localparam logic [CW:0]   N_CH_W  = (CW+1)'(N_CH);

    logic [0:0]    state_q,  state_d;
    logic [CW-1:0] rr_ptr_q, rr_ptr_d;
    logic [CW-1:0] grant_q,  grant_d;
    logic [M:0]    remain_q, remain_d;

    logic [N_CH-1:0] elig;
    logic            found;
    logic [CW-1:0]   pick;
    logic [M:0]      pick_cnt;
    logic [CW:0]     idx;
    logic            beat;

    always_comb begin
        elig = '0;
        for (int i = 0; i < N_CH; i++) begin
            elig[i] = (ch_count[i*(M+1) +: (M+1)] >= BURST_W) ||
                      (flush && (ch_count[i*(M+1) +: (M+1)] != '0));
        end
    end

    // Walk rr_ptr, rr_ptr+1, ... with an explicit wrap so non-power-of-2 N_CH never yields idx >= N_CH.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = '0;
        for (int k = 0; k < N_CH; k++) begin
            idx = {1'b0, rr_ptr_q} + (CW+1)'(k);
            if (idx >= N_CH_W) begin
                idx = idx - N_CH_W;
            end
            if (!found && elig[idx[CW-1:0]]) begin
                found = 1'b1;
                pick  = idx[CW-1:0];
            end
        end
    end

    assign pick_cnt = ch_count[pick*(M+1) +: (M+1)];

    always_comb begin
        ch_ready  = '0;
        out_valid = 1'b0;
        out_data  = '0;
        out_chan  = '0;
        out_last  = 1'b0;
        busy      = 1'b0;
        if (state_q == ST_XFER) begin
            ch_ready[grant_q] = out_ready;
            out_valid         = ch_valid[grant_q];
            out_data          = ch_data[grant_q*Nb +: Nb];
            out_chan          = grant_q;
            out_last          = (remain_q == ONE_W) && ch_valid[grant_q];
            busy              = 1'b1;
        end
    end

    assign beat = (state_q == ST_XFER) && ch_valid[grant_q] && out_ready;

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        grant_d  = grant_q;
        remain_d = remain_q;
        case (state_q)
            ST_IDLE: begin
                if (found) begin
                    grant_d  = pick;
                    remain_d = (pick_cnt >= BURST_W) ? BURST_W : pick_cnt;
                    state_d  = ST_XFER;
                end
            end
            ST_XFER: begin
                if (beat) begin
                    remain_d = remain_q - ONE_W;
                    if (remain_q == ONE_W) begin
                        state_d  = ST_IDLE;
                        rr_ptr_d = (grant_q == LAST_CH) ? '0 : grant_q + CW'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            rr_ptr_q <= '0;
            grant_q  <= '0;
            remain_q <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            grant_q  <= grant_d;
            remain_q <= remain_d;
        end
    end

endmodule

// File: tb/tb_fifo_burst_arbiter.sv
// Bench for fifo_burst_arbiter: bench-side FIFOs, a transaction-level arbiter model checked every cycle,
// and literal expectations on the captured beat log for each directed scenario.
module tb_fifo_burst_arbiter;
    localparam int N = 4, NB = 8, M = 2, BURST = 4, CW = 2;

    logic                clk = 1'b0;
    logic                reset_n;
    logic [N*(M+1)-1:0]  ch_count;
    logic [N-1:0]        ch_valid;
    logic [N*NB-1:0]     ch_data;
    logic [N-1:0]        ch_ready;
    logic                flush;
    logic                out_valid;
    logic                out_ready;
    logic [NB-1:0]       out_data;
    logic [CW-1:0]       out_chan;
    logic                out_last;
    logic                busy;

    always #5 clk = ~clk;

    fifo_burst_arbiter #(.N_CH(N), .Nb(NB), .M(M), .BURST(BURST)) dut (
        .clk(clk), .reset_n(reset_n), .ch_count(ch_count), .ch_valid(ch_valid),
        .ch_data(ch_data), .ch_ready(ch_ready), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_chan(out_chan),
        .out_last(out_last), .busy(busy)
    );

    int tests = 0, fails = 0, cyc = 0;

    logic [7:0] mem [N][64];
    int wr [N];
    int rd [N];
    bit gap [N];
    int cnt_drv [N];

    bit m_busy;
    int m_ch, m_left, m_ptr;

    int lg_chan [$];
    int lg_data [$];
    int lg_last [$];
    int lg_cyc  [$];
    int busy_cycles, stall_cycles;

    bit bp_mode;
    int bp_k;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            int sz;
            sz = wr[i] - rd[i];
            cnt_drv[i] = (sz > 7) ? 7 : sz;
            ch_count[i*(M+1) +: (M+1)] = 3'(cnt_drv[i]);
            ch_valid[i] = (sz > 0) && !gap[i];
            ch_data[i*NB +: NB] = (sz > 0) ? mem[i][rd[i]] : 8'h00;
        end
    endtask

    task automatic push(input int ch, input logic [7:0] d);
        mem[ch][wr[ch]] = d;
        wr[ch]++;
    endtask

    task automatic clear_log();
        lg_chan.delete(); lg_data.delete(); lg_last.delete(); lg_cyc.delete();
        busy_cycles = 0;
        stall_cycles = 0;
    endtask

    // One clock: compare at negedge, then advance FIFOs and model just after posedge.
    task automatic tick();
        logic          exp_valid;
        logic [N-1:0]  exp_ready;
        logic [N-1:0]  s_pop;
        bit            s_fire;
        bit            fnd;
        int            c;
        @(negedge clk);
        cyc++;
        exp_valid = m_busy && ch_valid[m_ch];
        exp_ready = '0;
        if (m_busy) exp_ready[m_ch] = out_ready;
        check("out_valid", out_valid, exp_valid);
        check("ch_ready", ch_ready, exp_ready);
        check("busy", busy, m_busy);
        check("out_last", out_last, exp_valid && (m_left == 1));
        if (exp_valid) begin
            check("out_chan", out_chan, m_ch);
            check("out_data", out_data, mem[m_ch][rd[m_ch]]);
        end
        if (out_valid && out_ready) begin
            lg_chan.push_back(int'(out_chan));
            lg_data.push_back(int'(out_data));
            lg_last.push_back(int'(out_last));
            lg_cyc.push_back(cyc);
        end
        if (busy) busy_cycles++;
        if (busy && !out_valid) stall_cycles++;
        s_fire = exp_valid && out_ready;
        s_pop  = ch_ready & ch_valid;
        @(posedge clk);
        #1;
        if (!reset_n) begin
            m_busy = 0; m_ptr = 0; m_left = 0; m_ch = 0;
        end else if (m_busy) begin
            if (s_fire) begin
                m_left--;
                if (m_left == 0) begin
                    m_busy = 0;
                    m_ptr = (m_ch + 1) % N;
                end
            end
        end else begin
            fnd = 0;
            for (int k = 0; k < N; k++) begin
                c = (m_ptr + k) % N;
                if (!fnd && (cnt_drv[c] >= BURST || (flush && cnt_drv[c] != 0))) begin
                    fnd = 1; m_busy = 1; m_ch = c;
                    m_left = (cnt_drv[c] < BURST) ? cnt_drv[c] : BURST;
                end
            end
        end
        for (int i = 0; i < N; i++) if (s_pop[i]) rd[i]++;
        if (bp_mode) begin
            bp_k++;
            out_ready = (bp_k % 3 == 0);
        end
        drive();
    endtask

    task automatic do_reset();
        reset_n = 0;
        flush = 0; out_ready = 1; bp_mode = 0; bp_k = 0;
        for (int i = 0; i < N; i++) begin wr[i] = 0; rd[i] = 0; gap[i] = 0; end
        m_busy = 0; m_ptr = 0; m_left = 0; m_ch = 0;
        drive();
        tick(); tick();
        reset_n = 1;
        clear_log();
    endtask

    task automatic wait_beats(input int n, input int budget, input string name);
        for (int b = 0; b < budget && lg_chan.size() < n; b++) tick();
        check(name, lg_chan.size() >= n, 1);
    endtask

    int t0;

    initial begin
        reset_n = 0;
        #2;
        // reset values with everything idle
        do_reset();
        check("reset_out_valid", out_valid, 0);
        check("reset_busy", busy, 0);

        // single burst on ch2
        for (int j = 0; j < 4; j++) push(2, 8'hA0 + 8'(j));
        drive();
        t0 = cyc;
        wait_beats(4, 20, "single_timeout");
        tick(); tick(); tick();
        check("single_nbeats", lg_chan.size(), 4);
        check("single_busy_cycles", busy_cycles, 4);
        if (lg_chan.size() >= 4) begin
            check("single_first_cycle", lg_cyc[0], t0 + 2);
            for (int j = 0; j < 4; j++) begin
                check("single_chan", lg_chan[j], 2);
                check("single_data", lg_data[j], 32'hA0 + j);
                check("single_last", lg_last[j], (j == 3) ? 1 : 0);
            end
        end

        // round-robin over four loaded channels
        do_reset();
        for (int c = 0; c < N; c++)
            for (int j = 0; j < 8; j++) push(c, 8'(c * 16 + j));
        drive();
        wait_beats(32, 80, "rr_timeout");
        tick(); tick();
        check("rr_nbeats", lg_chan.size(), 32);
        if (lg_chan.size() >= 32) begin
            for (int k = 0; k < 32; k++) begin
                check("rr_chan", lg_chan[k], (k / 4) % 4);
                check("rr_data", lg_data[k], ((k / 4) % 4) * 16 + (k / 16) * 4 + k % 4);
                check("rr_last", lg_last[k], (k % 4 == 3) ? 1 : 0);
            end
            check("rr_span", lg_cyc[31] - lg_cyc[0], 38);
        end

        // partial burst only moves under flush
        do_reset();
        for (int j = 0; j < 3; j++) push(1, 8'h10 + 8'(j));
        drive();
        repeat (10) tick();
        check("flush_hold_beats", lg_chan.size(), 0);
        check("flush_hold_busy", busy_cycles, 0);
        flush = 1;
        drive();
        wait_beats(3, 20, "flush_timeout");
        flush = 0;
        tick(); tick(); tick();
        check("flush_nbeats", lg_chan.size(), 3);
        check("flush_busy_cycles", busy_cycles, 3);
        if (lg_chan.size() >= 3) begin
            for (int j = 0; j < 3; j++) begin
                check("flush_chan", lg_chan[j], 1);
                check("flush_data", lg_data[j], 32'h10 + j);
                check("flush_last", lg_last[j], (j == 2) ? 1 : 0);
            end
        end

        // downstream backpressure on ch3
        do_reset();
        for (int j = 0; j < 4; j++) push(3, 8'h30 + 8'(j));
        bp_mode = 1; bp_k = 0; out_ready = 1;
        drive();
        wait_beats(4, 40, "bp_timeout");
        bp_mode = 0; out_ready = 1;
        drive();
        tick(); tick(); tick();
        check("bp_nbeats", lg_chan.size(), 4);
        if (lg_chan.size() >= 4) begin
            for (int j = 0; j < 4; j++) begin
                check("bp_chan", lg_chan[j], 3);
                check("bp_data", lg_data[j], 32'h30 + j);
                check("bp_last", lg_last[j], (j == 3) ? 1 : 0);
            end
        end

        // upstream gap of two cycles on ch0
        do_reset();
        for (int j = 0; j < 4; j++) push(0, 8'h50 + 8'(j));
        drive();
        wait_beats(2, 20, "gap_timeout1");
        gap[0] = 1;
        drive();
        tick(); tick();
        gap[0] = 0;
        drive();
        wait_beats(4, 20, "gap_timeout2");
        tick(); tick();
        check("gap_stall_cycles", stall_cycles, 2);
        check("gap_busy_cycles", busy_cycles, 6);
        check("gap_nbeats", lg_chan.size(), 4);
        if (lg_chan.size() >= 4) begin
            for (int j = 0; j < 4; j++) begin
                check("gap_data", lg_data[j], 32'h50 + j);
                check("gap_last", lg_last[j], (j == 3) ? 1 : 0);
            end
        end

        // asynchronous reset after the second beat of a ch1 burst
        do_reset();
        for (int j = 0; j < 4; j++) push(1, 8'h60 + 8'(j));
        drive();
        wait_beats(2, 20, "arst_timeout1");
        reset_n = 0;
        #1;
        check("arst_out_valid", out_valid, 0);
        check("arst_ch_ready", ch_ready, 0);
        check("arst_busy", busy, 0);
        m_busy = 0; m_ptr = 0; m_left = 0; m_ch = 0;
        clear_log();
        for (int j = 0; j < 4; j++) begin
            push(0, 8'h70 + 8'(j));
            push(2, 8'h80 + 8'(j));
        end
        drive();
        tick(); tick();
        reset_n = 1;
        wait_beats(4, 20, "arst_timeout2");
        if (lg_chan.size() >= 4) begin
            for (int j = 0; j < 4; j++) begin
                check("arst_chan", lg_chan[j], 0);
                check("arst_data", lg_data[j], 32'h70 + j);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1);
    end

endmodule
